// File: rtl/riscv_dump_pkg.sv
// rtl/riscv_dump_pkg.sv - shared FSM state type and constants for the memory dump reader
package riscv_dump_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } dump_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_ADDR_STEP = 4;

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - holds one 32-bit word and emits it LSB-first, one byte per advance
module word_byte_serializer
    import riscv_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        advance,
    output logic [7:0]  byte_data,
    output logic        last_byte
);

    logic [31:0] shreg;
    logic [1:0]  byte_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            shreg    <= word;
            byte_idx <= '0;
        end else if (advance) begin
            shreg    <= {8'h00, shreg[31:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign byte_data = shreg[7:0];
    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - streams a range of RAM words out as bytes, one word read at a time
module mem_dump_reader
    import riscv_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    dump_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] words_left;
    logic [7:0]            byte_data;
    logic                  last_byte;
    logic                  handshake;
    logic                  last_word;

    assign handshake = (state == SEND) && out_ready;
    assign last_word = (words_left == ADDR_WIDTH'(1));

    word_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (state == WAIT),
        .word      (mem_rdata),
        .advance   (handshake),
        .byte_data (byte_data),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // words_left counts down to 1, so a full-range count never has to hold 2^ADDR_WIDTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            words_left <= '0;
        end else if (state == IDLE && start && word_count != '0) begin
            addr       <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
            words_left <= word_count;
        end else if (handshake && last_byte && !last_word) begin
            addr       <= addr + ADDR_WIDTH'(WORD_ADDR_STEP);
            words_left <= words_left - ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count != '0) ? REQ : FIN;
                end
            end
            REQ:  state_next = WAIT;
            WAIT: state_next = SEND;
            SEND: begin
                if (handshake && last_byte) begin
                    state_next = last_word ? FIN : REQ;
                end
            end
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign mem_req   = (state == REQ);
    assign mem_addr  = mem_req ? addr : '0;
    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? byte_data : 8'h00;
    assign out_last  = out_valid && last_byte && last_word;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - directed self-checking bench for mem_dump_reader
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, mem_req;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_valid, out_last;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
    int done_cnt, stall_err, valid_cnt;
    logic [7:0]  byte_q[$];
    logic        last_q[$];
    logic [15:0] addr_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] ram [0:16383];

    mem_dump_reader #(.ADDR_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_req) mem_rdata <= ram[mem_addr[15:2]];
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_err++;
            if (out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                byte_q.push_back(out_data);
                last_q.push_back(out_last);
                last_hs_cyc = cyc;
            end
            if (mem_req) addr_q.push_back(mem_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic clear_mon();
        byte_q.delete();
        last_q.delete();
        addr_q.delete();
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
        stall_err = 0;
        valid_cnt = 0;
    endtask

    task automatic do_start(input logic [15:0] base, input logic [15:0] count);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        word_count = count;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_cnt > 0) break;
        end
        n_total++;
        if (done_cnt == 0) $display("FAIL %s_timeout: no done within %0d cycles", name, limit);
        else n_pass++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({busy, done, mem_req, out_valid, out_last} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_req, out_valid, out_last});
        else n_pass++;
        n_total++;
        if ({mem_addr, out_data} !== 24'h0)
            $display("FAIL reset_data: got %h want 000000", {mem_addr, out_data});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] exp_bytes = 64'h0807060504030201;
        logic [7:0]  lmask = '0;
        clear_mon();
        out_ready = 1'b1;
        do_start(16'h0100, 16'd2);
        wait_done(60, "basic");
        n_total++;
        if (byte_q.size() != 8) $display("FAIL basic_count: got %0d want 8", byte_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < byte_q.size(); i++) begin
            n_total++;
            if (byte_q[i] !== exp_bytes[8*i +: 8])
                $display("FAIL basic_byte%0d: got %h want %h", i, byte_q[i], exp_bytes[8*i +: 8]);
            else n_pass++;
        end
        for (int i = 0; i < 8 && i < last_q.size(); i++) lmask[i] = last_q[i];
        n_total++;
        if (lmask !== 8'h80) $display("FAIL basic_last: got %b want 10000000", lmask);
        else n_pass++;
        n_total++;
        if (addr_q.size() != 2 || addr_q[0] !== 16'h0100 || addr_q[1] !== 16'h0104)
            $display("FAIL basic_addr: got %0d reqs first %h want 0100,0104", addr_q.size(),
                     addr_q.size() > 0 ? addr_q[0] : 16'hxxxx);
        else n_pass++;
        n_total++;
        if (first_valid_cyc - start_cyc != 3)
            $display("FAIL basic_latency: got %0d want 3", first_valid_cyc - start_cyc);
        else n_pass++;
        n_total++;
        if (done_cyc - last_hs_cyc != 1 || done_cnt != 1)
            $display("FAIL basic_done: got delay %0d pulses %0d want 1 1", done_cyc - last_hs_cyc, done_cnt);
        else n_pass++;
        n_total++;
        if (valid_cnt != 8) $display("FAIL basic_throughput: got %0d valid cycles want 8", valid_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_bytes = 64'h0807060504030201;
        clear_mon();
        do_start(16'h0100, 16'd2);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            out_ready = ((i % 4) == 0 || (i % 4) == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (done_cnt > 0) break;
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        n_total++;
        if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
        else n_pass++;
        n_total++;
        if (byte_q.size() != 8) $display("FAIL bp_count: got %0d want 8", byte_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < byte_q.size(); i++) begin
            n_total++;
            if (byte_q[i] !== exp_bytes[8*i +: 8])
                $display("FAIL bp_byte%0d: got %h want %h", i, byte_q[i], exp_bytes[8*i +: 8]);
            else n_pass++;
        end
        n_total++;
        if (stall_err != 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        clear_mon();
        do_start(16'h0100, 16'd0);
        repeat (4) @(posedge clk);
        n_total++;
        if (done_cnt != 1 || done_cyc - start_cyc != 1)
            $display("FAIL zero_done: got pulses %0d delay %0d want 1 1", done_cnt, done_cyc - start_cyc);
        else n_pass++;
        n_total++;
        if (addr_q.size() != 0 || valid_cnt != 0)
            $display("FAIL zero_quiet: got %0d reqs %0d valids want 0 0", addr_q.size(), valid_cnt);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic [95:0] exp_bytes = 96'h0C0B0A090807060504030201;
        clear_mon();
        do_start(16'h0100, 16'd3);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 16'h0200;
        word_count = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(80, "ignore");
        n_total++;
        if (byte_q.size() != 12) $display("FAIL ignore_count: got %0d want 12", byte_q.size());
        else n_pass++;
        for (int i = 0; i < 12 && i < byte_q.size(); i++) begin
            n_total++;
            if (byte_q[i] !== exp_bytes[8*i +: 8])
                $display("FAIL ignore_byte%0d: got %h want %h", i, byte_q[i], exp_bytes[8*i +: 8]);
            else n_pass++;
        end
        n_total++;
        if (addr_q.size() != 3 || addr_q[2] !== 16'h0108 || done_cnt != 1)
            $display("FAIL ignore_addr: got %0d reqs %0d dones want 3 1", addr_q.size(), done_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [63:0] exp_bytes = 64'h44332211DDCCBBAA;
        clear_mon();
        do_start(16'hFFFE, 16'd2);
        wait_done(60, "wrap");
        n_total++;
        if (addr_q.size() != 2 || addr_q[0] !== 16'hFFFC || addr_q[1] !== 16'h0000)
            $display("FAIL wrap_addr: got %0d reqs first %h want FFFC,0000", addr_q.size(),
                     addr_q.size() > 0 ? addr_q[0] : 16'hxxxx);
        else n_pass++;
        n_total++;
        if (byte_q.size() != 8) $display("FAIL wrap_count: got %0d want 8", byte_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < byte_q.size(); i++) begin
            n_total++;
            if (byte_q[i] !== exp_bytes[8*i +: 8])
                $display("FAIL wrap_byte%0d: got %h want %h", i, byte_q[i], exp_bytes[8*i +: 8]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_bytes = 32'h08070605;
        logic [3:0]  lmask = '0;
        clear_mon();
        out_ready = 1'b1;
        do_start(16'h0100, 16'd2);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if ({out_valid, busy, mem_req} !== 3'b000)
            $display("FAIL rstmid_abort: got %b want 000", {out_valid, busy, mem_req});
        else n_pass++;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (done_cnt != 0 || busy !== 1'b0)
            $display("FAIL rstmid_nodone: got dones %0d busy %b want 0 0", done_cnt, busy);
        else n_pass++;
        clear_mon();
        do_start(16'h0104, 16'd1);
        wait_done(40, "rstmid");
        n_total++;
        if (byte_q.size() != 4) $display("FAIL rstmid_count: got %0d want 4", byte_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < byte_q.size(); i++) begin
            n_total++;
            if (byte_q[i] !== exp_bytes[8*i +: 8])
                $display("FAIL rstmid_byte%0d: got %h want %h", i, byte_q[i], exp_bytes[8*i +: 8]);
            else n_pass++;
        end
        for (int i = 0; i < 4 && i < last_q.size(); i++) lmask[i] = last_q[i];
        n_total++;
        if (lmask !== 4'b1000) $display("FAIL rstmid_last: got %b want 1000", lmask);
        else n_pass++;
    endtask

    initial begin
        ram[16'h0100 >> 2] = 32'h04030201;
        ram[16'h0104 >> 2] = 32'h08070605;
        ram[16'h0108 >> 2] = 32'h0C0B0A09;
        ram[16'h0200 >> 2] = 32'hEEEEEEEE;
        ram[16'hFFFC >> 2] = 32'hDDCCBBAA;
        ram[16'h0000 >> 2] = 32'h44332211;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_busy_ignore();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
